// File: rtl/mem_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous memory.
// After reset it can sweep every location to INIT_VALUE before granting accesses.
module mem_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam state_t RESET_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rr_ptr_q, rr_ptr_d;   // 0 = A has priority, 1 = B
  logic                  a_rvalid_q, b_rvalid_q;
  logic                  init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      rr_ptr_q    <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      init_done_q <= (INIT_EN == 0);
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      a_rvalid_q  <= a_gnt & ~a_we;
      b_rvalid_q  <= b_gnt & ~b_we;
      // Registered from the next state so it lines up with the first RUN cycle.
      init_done_q <= (state_d == S_RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;

    case (state_q)
      S_INIT: begin
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = init_cnt_q;
        mem_din    = INIT_VALUE;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = S_RUN;
        end
      end
      default: begin
        if (a_req && (!b_req || !rr_ptr_q)) begin
          a_gnt = 1'b1;
        end else if (b_req) begin
          b_gnt = 1'b1;
        end

        if (a_gnt) begin
          mem_cs   = 1'b1;
          mem_we   = a_we;
          mem_re   = ~a_we;
          mem_addr = a_addr;
          mem_din  = a_wdata;
          rr_ptr_d = 1'b1;
        end else if (b_gnt) begin
          mem_cs   = 1'b1;
          mem_we   = b_we;
          mem_re   = ~b_we;
          mem_addr = b_addr;
          mem_din  = b_wdata;
          rr_ptr_d = 1'b0;
        end
      end
    endcase
  end

  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = mem_dout;
  assign b_rdata   = mem_dout;
  assign init_done = init_done_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares one single-port synchronous memory (cs/we/re/addr/data_in/data_out, 1-cycle registered read, write wins over read) between two requesters, A and B.
- After reset, optionally sweeps every address to INIT_VALUE.
- Then grants one access per cycle, round-robin, and returns read data with a 1-cycle valid strobe.
- Sits between client logic and the memory instance.

Parameters:
- DATA_WIDTH, 8, data width of memory and requester data ports
- ADDR_WIDTH, 8, address width; memory depth 2**ADDR_WIDTH
- INIT_EN, 1, 1 = clear memory after reset; 0 = skip init
- INIT_VALUE, 0, word written to every location during init

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A access request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_WIDTH  A address
- a_wdata  in  DATA_WIDTH  A write data
- a_gnt  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  DATA_WIDTH  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout  in  DATA_WIDTH  memory read data (registered inside memory)
- init_done  out  1  high once the arbiter is in RUN

Behaviour:
- One clock clk. Reset rst_n is asynchronous, active-low.
- FSM states: INIT, RUN.
  - Reset state: INIT if INIT_EN=1, else RUN.
  - INIT: each cycle drives mem_cs=1, mem_we=1, mem_re=0, mem_addr=init_cnt, mem_din=INIT_VALUE; init_cnt increments.
  - INIT -> RUN on the cycle after the write to address 2**ADDR_WIDTH-1. Init takes exactly 2**ADDR_WIDTH cycles.
  - In INIT, a_gnt=b_gnt=0; requests are held off, not dropped.
  - init_done is a registered copy of state==RUN; reset value is 1 if INIT_EN=0, else 0.
- Reset values: init_cnt=0, rr_ptr=A, a_rvalid=b_rvalid=0. All combinational outputs are 0 while in INIT without an access, or with no grant.
- Handshake: a transfer occurs in a cycle with req & gnt. Requester holds req/we/addr/wdata stable until gnt. gnt is combinational from req, rr_ptr and state.
- Arbitration in RUN:
  - Only one requester asserts req: it is granted that cycle, back-to-back every cycle if it holds req.
  - Both assert req: the side named by rr_ptr is granted.
  - rr_ptr updates on every grant to point at the non-granted side. With no grant, rr_ptr holds.
  - At most one gnt per cycle.
- Memory drive, combinational from the winner: mem_cs=1, mem_we=winner we, mem_re=~winner we, mem_addr/mem_din from the winner.
  - No winner: mem_cs=mem_we=mem_re=0; mem_addr and mem_din are 0.
- Read return:
  - x_rvalid is registered: 1 in the cycle after a granted read by x, else 0.
  - x_rdata = mem_dout, combinational passthrough; meaningful only when x_rvalid=1.
  - Read latency is 1 cycle from grant. Back-to-back reads pipeline with no bubble.
- Write latency: data is visible to a read granted in the following cycle or later.
- Reset mid-INIT: the sweep restarts from address 0.
- Reset mid-RUN: a pending rvalid is dropped.
- Address wrap: init_cnt is ADDR_WIDTH bits. Termination is detected at all-ones, not by overflow.

Test Plan:
- Reset release with INIT_EN=1, defaults: 256 consecutive writes of 0x00 to addresses 0x00..0xFF. init_done rises the cycle after address 0xFF. No gnt during init.
- RUN: A writes 0x5A to 0x10; next cycle A reads 0x10 -> a_gnt=1 both cycles. a_rvalid=1 with a_rdata=0x5A one cycle after the read grant. b_rvalid stays 0.
- Both requesting reads continuously, rr_ptr=A after reset: grants alternate A,B,A,B. Each rvalid appears exactly 1 cycle after its own grant.
- Only B requesting 4 reads of 0x01..0x04 (preloaded 0x11..0x44): b_gnt high 4 consecutive cycles. b_rvalid high 4 consecutive cycles returning 0x11,0x22,0x33,0x44.
- A requests during INIT: held off; A is granted on the first RUN cycle. A holds req stable throughout.
- Assert rst_n low at init_cnt=0x80: on release, sweep restarts at 0x00. Total 256 further init cycles before init_done=1.
